// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: functional-unit indices,
// default sizes and the round-robin pointer helper.
package cdb_arbiter_pkg;

    // Functional-unit indices as seen on the CDB request vector.
    localparam int FU_ALU    = 0;
    localparam int FU_BR_ALU = 1;
    localparam int FU_MUL    = 2;
    localparam int FU_DIV    = 3;
    localparam int FU_MEM    = 4;

    // Default number of requesters (one per functional unit above).
    localparam int NUM_FU_DEFAULT = 5;

    // Result width carried on the bus.
    localparam int CDB_DATA_W = 32;

    // ROB tag width; must match the reorder buffer's index width.
    localparam int ROB_TAG_W = 3;

    // Width of the producer id broadcast with each result.
    localparam int FU_ID_W = 3;

    // Pointer value that follows a grant to index idx in a ring of n.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin priority picker: scans the request vector starting at the
// pointer, ascending with wrap, and returns a one-hot grant for the first
// requester found together with its index.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req_in,
    input  logic [PTR_W-1:0] ptr_in,
    output logic [N-1:0]     grant_out,
    output logic [PTR_W-1:0] grant_idx_out,
    output logic             grant_any_out
);

    int cand;

    // First requester at or after ptr_in (modulo N) wins.
    always_comb begin
        grant_out     = '0;
        grant_idx_out = '0;
        grant_any_out = 1'b0;
        cand          = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_in) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_any_out && req_in[PTR_W'(cand)]) begin
                grant_any_out             = 1'b1;
                grant_out[PTR_W'(cand)]   = 1'b1;
                grant_idx_out             = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Functional units present results; one of them is
// granted per cycle (round-robin) and its result is captured into a single
// broadcast register that drives the CDB until the consumer accepts it.
//
// Handshake: a broadcast is transferred when cdb_valid_out=1 and
// cdb_ready_in=1 in the same cycle. The broadcast register may be reloaded in
// that very cycle, so back-to-back broadcasts run at one per cycle. While a
// broadcast is waiting (valid=1, ready=0) its fields stay stable and no FU is
// granted. An FU is told its result was taken through fu_read_out, which is
// combinational and at most one-hot. flush_in squashes both the grant of the
// current cycle and the broadcast register content.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_DEFAULT,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int ROB_IDX_W = ROB_TAG_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_FU-1:0]           fu_valid_in,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data_in,
    input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in,
    output logic [NUM_FU-1:0]           fu_read_out,
    input  logic                        cdb_ready_in,
    input  logic                        flush_in,
    output logic                        cdb_valid_out,
    output logic [DATA_W-1:0]           cdb_data_out,
    output logic [ROB_IDX_W-1:0]        cdb_rob_idx_out,
    output logic [2:0]                  cdb_fu_id_out
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Round-robin pointer: index where the next search starts.
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    // Broadcast register.
    logic                 cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [FU_ID_W-1:0]   cdb_fu_id_q, cdb_fu_id_d;

    // Picker results before qualification by the output stage.
    logic [NUM_FU-1:0]    arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic                 arb_any;

    logic                 can_load;
    logic                 grant_fire;

    rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_in        (fu_valid_in),
        .ptr_in        (rr_ptr_q),
        .grant_out     (arb_grant),
        .grant_idx_out (arb_idx),
        .grant_any_out (arb_any)
    );

    // The register can take a new result when it is empty or being drained
    // this cycle; reset and flush suppress any grant.
    always_comb begin
        can_load    = rst_in && !flush_in && (!cdb_valid_q || cdb_ready_in);
        grant_fire  = can_load && arb_any;
        fu_read_out = grant_fire ? arb_grant : '0;
    end

    // Next-state for the broadcast register and the round-robin pointer.
    always_comb begin
        cdb_valid_d   = cdb_valid_q;
        cdb_data_d    = cdb_data_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_fu_id_d   = cdb_fu_id_q;
        rr_ptr_d      = rr_ptr_q;

        if (flush_in) begin
            // Squash the in-flight broadcast; pointer stays where it is.
            cdb_valid_d = 1'b0;
            cdb_fu_id_d = '0;
        end else if (grant_fire) begin
            cdb_valid_d   = 1'b1;
            cdb_data_d    = fu_data_in[int'(arb_idx)*DATA_W +: DATA_W];
            cdb_rob_idx_d = fu_rob_idx_in[int'(arb_idx)*ROB_IDX_W +: ROB_IDX_W];
            cdb_fu_id_d   = FU_ID_W'(arb_idx);
            rr_ptr_d      = PTR_W'(rr_next(int'(arb_idx), NUM_FU));
        end else if (cdb_valid_q && cdb_ready_in) begin
            // Consumed with nothing to replace it: bus goes idle.
            cdb_valid_d = 1'b0;
            cdb_fu_id_d = '0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_data_q    <= '0;
            cdb_rob_idx_q <= '0;
            cdb_fu_id_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_data_q    <= cdb_data_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_fu_id_q   <= cdb_fu_id_d;
        end
    end

    assign cdb_valid_out   = cdb_valid_q;
    assign cdb_data_out    = cdb_data_q;
    assign cdb_rob_idx_out = cdb_rob_idx_q;
    assign cdb_fu_id_out   = cdb_fu_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural model with a result scoreboard.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int RW = 3;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [N-1:0]    fu_valid_in;
    logic [N*DW-1:0] fu_data_in;
    logic [N*RW-1:0] fu_rob_idx_in;
    logic [N-1:0]    fu_read_out;
    logic            cdb_ready_in;
    logic            flush_in;
    logic            cdb_valid_out;
    logic [DW-1:0]   cdb_data_out;
    logic [RW-1:0]   cdb_rob_idx_out;
    logic [2:0]      cdb_fu_id_out;

    logic [DW-1:0] fu_d[N];
    logic [RW-1:0] fu_r[N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            fu_data_in[k*DW +: DW]    = fu_d[k];
            fu_rob_idx_in[k*RW +: RW] = fu_r[k];
        end
    end

    cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .ROB_IDX_W(RW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .fu_valid_in     (fu_valid_in),
        .fu_data_in      (fu_data_in),
        .fu_rob_idx_in   (fu_rob_idx_in),
        .fu_read_out     (fu_read_out),
        .cdb_ready_in    (cdb_ready_in),
        .flush_in        (flush_in),
        .cdb_valid_out   (cdb_valid_out),
        .cdb_data_out    (cdb_data_out),
        .cdb_rob_idx_out (cdb_rob_idx_out),
        .cdb_fu_id_out   (cdb_fu_id_out)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic fl);
        fu_valid_in  = v;
        cdb_ready_in = rdy;
        flush_in     = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    // Behavioural model state and scoreboard.
    int            m_ptr;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_idx;
    logic [2:0]    m_fu;
    logic [3+DW+RW-1:0] exp_q[$];
    logic          pend[N];
    int            wait_cnt[N];

    task automatic do_reset();
        rst_in = 1'b0;
        drive('1, 1'b1, 1'b0);
        #1;
        check("reset_grant", 64'(fu_read_out), 64'd0);
        check("reset_valid", 64'(cdb_valid_out), 64'd0);
        check("reset_data", 64'(cdb_data_out), 64'd0);
        check("reset_fu_id", 64'(cdb_fu_id_out), 64'd0);
        next_cycle();
        rst_in = 1'b1;
        drive('0, 1'b1, 1'b0);
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_idx = '0; m_fu = '0;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            wait_cnt[k] = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         fl;
        logic [N-1:0] g;
        logic         ov;
        logic [2:0]   ofu;
    } vec_t;

    vec_t tbl[17];

    initial begin
        fu_valid_in = '0; cdb_ready_in = 1'b0; flush_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            fu_d[k] = 32'(100 + k);
            fu_r[k] = RW'(k);
        end

        //          v         rdy   fl    grant     ov    fu
        tbl[0]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b0, 3'd0};
        tbl[1]  = '{5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1, 3'd0};
        tbl[2]  = '{5'b11111, 1'b1, 1'b0, 5'b00100, 1'b1, 3'd1};
        tbl[3]  = '{5'b11111, 1'b1, 1'b0, 5'b01000, 1'b1, 3'd2};
        tbl[4]  = '{5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1, 3'd3};
        tbl[5]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd4};
        tbl[6]  = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 3'd0};
        tbl[7]  = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0};
        tbl[8]  = '{5'b01010, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0};
        tbl[9]  = '{5'b01010, 1'b1, 1'b0, 5'b00010, 1'b0, 3'd0};
        tbl[10] = '{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 3'd1};
        tbl[11] = '{5'b01010, 1'b1, 1'b0, 5'b01000, 1'b1, 3'd1};
        tbl[12] = '{5'b01010, 1'b1, 1'b0, 5'b00010, 1'b1, 3'd3};
        tbl[13] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 3'd1};
        tbl[14] = '{5'b10000, 1'b0, 1'b0, 5'b10000, 1'b0, 3'd0};
        tbl[15] = '{5'b00001, 1'b0, 1'b1, 5'b00000, 1'b1, 3'd4};
        tbl[16] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0};

        next_cycle();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].rdy, tbl[i].fl);
            sample();
            check($sformatf("tbl%0d_grant", i), 64'(fu_read_out), 64'(tbl[i].g));
            check($sformatf("tbl%0d_valid", i), 64'(cdb_valid_out), 64'(tbl[i].ov));
            check($sformatf("tbl%0d_fu_id", i), 64'(cdb_fu_id_out), 64'(tbl[i].ofu));
            if (tbl[i].ov) begin
                check($sformatf("tbl%0d_data", i), 64'(cdb_data_out), 64'(100 + int'(tbl[i].ofu)));
                check($sformatf("tbl%0d_rob", i), 64'(cdb_rob_idx_out), 64'(tbl[i].ofu));
            end
            next_cycle();
        end

        // ---- single request ----
        do_reset();
        fu_d[0] = 32'h0000_002A; fu_r[0] = 3'd3;
        drive(5'b00001, 1'b1, 1'b0);
        sample();
        check("single_grant", 64'(fu_read_out), 64'b00001);
        next_cycle();
        drive('0, 1'b1, 1'b0);
        sample();
        check("single_valid", 64'(cdb_valid_out), 64'd1);
        check("single_data", 64'(cdb_data_out), 64'd42);
        check("single_rob", 64'(cdb_rob_idx_out), 64'd3);
        check("single_fu_id", 64'(cdb_fu_id_out), 64'd0);
        next_cycle();

        // ---- backpressure ----
        do_reset();
        fu_d[2] = 32'hFFFF_FFF9; fu_r[2] = 3'd5;
        drive(5'b00100, 1'b1, 1'b0);
        sample();
        check("bp_first_grant", 64'(fu_read_out), 64'b00100);
        next_cycle();
        fu_d[0] = 32'd5; fu_r[0] = 3'd1;
        drive(5'b00001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("bp_hold%0d_grant", c), 64'(fu_read_out), 64'd0);
            check($sformatf("bp_hold%0d_valid", c), 64'(cdb_valid_out), 64'd1);
            check($sformatf("bp_hold%0d_data", c), 64'(cdb_data_out), 64'hFFFF_FFF9);
            check($sformatf("bp_hold%0d_rob", c), 64'(cdb_rob_idx_out), 64'd5);
            check($sformatf("bp_hold%0d_fu_id", c), 64'(cdb_fu_id_out), 64'd2);
            next_cycle();
        end
        drive(5'b00001, 1'b1, 1'b0);
        sample();
        check("bp_release_grant", 64'(fu_read_out), 64'b00001);
        next_cycle();
        drive('0, 1'b1, 1'b0);
        sample();
        check("bp_next_valid", 64'(cdb_valid_out), 64'd1);
        check("bp_next_data", 64'(cdb_data_out), 64'd5);
        check("bp_next_fu_id", 64'(cdb_fu_id_out), 64'd0);
        next_cycle();

        // ---- flush ----
        for (int k = 0; k < N; k++) begin
            fu_d[k] = 32'(100 + k);
            fu_r[k] = RW'(k);
        end
        do_reset();
        drive(5'b00001, 1'b1, 1'b0);
        sample();
        check("flush_pre_grant", 64'(fu_read_out), 64'b00001);
        next_cycle();
        drive(5'b01010, 1'b1, 1'b1);
        sample();
        check("flush_grant", 64'(fu_read_out), 64'd0);
        check("flush_valid_before", 64'(cdb_valid_out), 64'd1);
        next_cycle();
        drive(5'b01010, 1'b1, 1'b0);
        sample();
        check("flush_valid_after", 64'(cdb_valid_out), 64'd0);
        check("flush_fu_id_after", 64'(cdb_fu_id_out), 64'd0);
        check("flush_post_grant", 64'(fu_read_out), 64'b00010);
        next_cycle();

        // ---- asynchronous reset mid-broadcast ----
        do_reset();
        drive(5'b00001, 1'b0, 1'b0);
        sample();
        next_cycle();
        drive(5'b11111, 1'b0, 1'b0);
        sample();
        check("areset_pre_valid", 64'(cdb_valid_out), 64'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("areset_valid", 64'(cdb_valid_out), 64'd0);
        check("areset_data", 64'(cdb_data_out), 64'd0);
        check("areset_rob", 64'(cdb_rob_idx_out), 64'd0);
        check("areset_fu_id", 64'(cdb_fu_id_out), 64'd0);
        check("areset_grant", 64'(fu_read_out), 64'd0);
        next_cycle();
        rst_in = 1'b1;
        drive(5'b10001, 1'b1, 1'b0);
        sample();
        check("areset_first_grant", 64'(fu_read_out), 64'b00001);
        next_cycle();

        // ---- randomized run against the model ----
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [N-1:0] v;
            logic [N-1:0] eg;
            logic rdy, fl, m_can;
            int gk;
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    fu_d[k] = $urandom;
                    fu_r[k] = RW'($urandom_range(0, 7));
                end
                v[k] = pend[k];
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            drive(v, rdy, fl);

            m_can = !fl && (!m_valid || rdy);
            gk = -1;
            if (m_can) begin
                for (int j = 0; j < N; j++) begin
                    int k;
                    k = (m_ptr + j) % N;
                    if (gk < 0 && pend[k]) gk = k;
                end
            end
            eg = '0;
            if (gk >= 0) eg[gk] = 1'b1;

            sample();
            check("rnd_grant", 64'(fu_read_out), 64'(eg));
            check("rnd_valid", 64'(cdb_valid_out), 64'(m_valid));
            check("rnd_fu_id", 64'(cdb_fu_id_out), m_valid ? 64'(m_fu) : 64'd0);
            if (m_valid) begin
                check("rnd_data", 64'(cdb_data_out), 64'(m_data));
                check("rnd_rob", 64'(cdb_rob_idx_out), 64'(m_idx));
            end

            // Scoreboard: each granted result must leave the bus exactly once.
            if (cdb_valid_out && (rdy || fl)) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 64'(cdb_fu_id_out), 64'h1_0000);
                end else begin
                    check("sb_result", 64'({cdb_fu_id_out, cdb_data_out, cdb_rob_idx_out}),
                          64'(exp_q.pop_front()));
                end
            end
            if (gk >= 0) begin
                exp_q.push_back({3'(gk), fu_d[gk], fu_r[gk]});
            end

            // Fairness: a waiting FU is granted within N loadable cycles.
            for (int k = 0; k < N; k++) begin
                if (pend[k]) begin
                    if (k == gk) begin
                        check("rnd_fairness", 64'(wait_cnt[k] < N), 64'd1);
                        wait_cnt[k] = 0;
                    end else if (m_can) begin
                        wait_cnt[k]++;
                    end
                end
            end

            // Model update.
            if (fl) begin
                m_valid = 1'b0;
                m_fu    = '0;
            end else if (gk >= 0) begin
                m_valid = 1'b1;
                m_data  = fu_d[gk];
                m_idx   = fu_r[gk];
                m_fu    = 3'(gk);
                m_ptr   = (gk + 1) % N;
                pend[gk] = 1'b0;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
                m_fu    = '0;
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 5, number of requesting functional units (0=ALU, 1=BR_ALU, 2=MUL, 3=DIV, 4=MEM).
REQ-002 Parameter DATA_W, default 32, result width.
REQ-003 Parameter ROB_IDX_W, default 3, ROB index width.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  reset; asynchronous assert, active-low.
REQ-006 fu_valid_in  input  NUM_FU  per-FU result-available flag.
REQ-007 fu_data_in  input  NUM_FU x DATA_W  per-FU signed result.
REQ-008 fu_rob_idx_in  input  NUM_FU x ROB_IDX_W  per-FU destination ROB index.
REQ-009 fu_read_out  output  NUM_FU  one-hot grant; drives each FU's read_in.
REQ-010 cdb_ready_in  input  1  ROB/RS side can accept a broadcast this cycle.
REQ-011 flush_in  input  1  misprediction flush; squash in-flight broadcast.
REQ-012 cdb_valid_out  output  1  broadcast valid.
REQ-013 cdb_data_out  output  DATA_W  broadcast result.
REQ-014 cdb_rob_idx_out  output  ROB_IDX_W  broadcast ROB tag.
REQ-015 cdb_fu_id_out  output  3  index of FU that produced the broadcast.

Function
REQ-016 Grant is combinational: fu_read_out has at most one bit set, only for an FU with fu_valid_in=1, and only when the output stage can load (REQ-019).
REQ-017 Arbitration is round-robin: search starts at rr_ptr, ascending with wrap modulo NUM_FU; first valid requester wins.
REQ-018 On a grant to FU k, rr_ptr loads (k+1) mod NUM_FU at the clock edge; with no grant, rr_ptr holds.
REQ-019 Output stage is one register; it can load when it is empty or cdb_ready_in=1 (broadcast consumed this cycle).
REQ-020 Latency: request granted in cycle t appears on cdb_*_out in cycle t+1 with cdb_valid_out=1.
REQ-021 While cdb_valid_out=1 and cdb_ready_in=0, cdb_data_out, cdb_rob_idx_out and cdb_fu_id_out hold stable; no grant is issued.
REQ-022 cdb_valid_out=1 with cdb_ready_in=1 and no new grant: cdb_valid_out goes 0 next cycle.
REQ-023 Consume and new grant in the same cycle: the output register reloads back-to-back; full throughput is one broadcast per cycle.
REQ-024 flush_in=1: fu_read_out forced to 0 that cycle; cdb_valid_out cleared next cycle; rr_ptr unchanged.
REQ-025 Fairness: a requester holding fu_valid_in=1 continuously, with cdb_ready_in=1 and no flush, is granted within NUM_FU cycles.
REQ-026 fu_valid_in for an FU not granted is ignored that cycle; the FU keeps its result (no loss).
REQ-027 cdb_fu_id_out is 0 whenever cdb_valid_out=0.

Reset
REQ-028 rst_in low asynchronously clears: cdb_valid_out=0, cdb_data_out=0, cdb_rob_idx_out=0, cdb_fu_id_out=0, rr_ptr=0.
REQ-029 fu_read_out is 0 while rst_in is low, regardless of requests.
REQ-030 Reset mid-broadcast discards the held result; first grant after release goes to the lowest-index valid FU at or after index 0.

Structure
REQ-031 FU index constants (FU_ALU..FU_MEM) and NUM_FU default live in the shared types package; ROB_IDX_W matches the ROB definition there.
REQ-032 One sub-module, rr_arbiter (request vector + pointer -> one-hot grant), instantiated once; the output register and pointer stay in cdb_arbiter.

Verification
REQ-033 Single request: fu_valid_in=5'b00001, data 32'h0000_002A, idx 3, cdb_ready_in=1 -> fu_read_out=00001 same cycle; next cycle cdb_valid_out=1, data 42, rob_idx 3, fu_id 0.
REQ-034 All five valid continuously, ready=1, rr_ptr=0 -> grants FU 0,1,2,3,4,0 on consecutive cycles; cdb_fu_id_out follows one cycle later.
REQ-035 Backpressure: broadcast from FU 2 (data -7) held with cdb_ready_in=0 for 3 cycles -> outputs stable at -7, fu_read_out=0; ready=1 -> new grant same cycle, next broadcast following cycle.
REQ-036 Flush: FU 1 and FU 3 valid, flush_in=1 -> no grant that cycle, cdb_valid_out=0 next cycle, rr_ptr unchanged; flush low -> FU 1 granted first (rr_ptr=0).
REQ-037 Async reset: assert rst_in low mid-clock while cdb_valid_out=1 -> all outputs 0 immediately, before the next clock edge.
REQ-038 Random stimulus, 10k cycles: at most one grant per cycle, no result lost or duplicated versus a scoreboard, max wait per FU <= 5 ready cycles.
